// File: rtl/dispatch_queue.sv
// dispatch_queue
//   Circular FIFO between decode and rename/dispatch. Accepts decoded
//   instructions over a valid/ready handshake, presents them in order,
//   and drops every held entry on a flush (jump/redirect).
//
//   Optional feature: define DISPATCH_QUEUE_BYPASS_EN to pass an incoming
//   entry straight to the output when the queue is empty (zero-cycle latency).
//
//   Parameters:
//     DEPTH               number of entries (power of two, >= 2)
//     INSTRUCTION_DECODED payload type of one decoded instruction
//   Ports:
//     clk            core clock, rising edge
//     reset          asynchronous, active-high reset
//     flush          synchronous discard of all entries
//     instruction_i  decoded instruction from decode
//     valid_i        instruction_i is valid
//     ready_i        queue accepts instruction_i this cycle
//     instruction_o  head entry to rename/dispatch
//     valid_o        instruction_o is valid
//     ready_o        downstream consumes instruction_o this cycle
//     count          number of held entries
module dispatch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter type INSTRUCTION_DECODED = logic [31:0]
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  INSTRUCTION_DECODED             instruction_i,
    input  logic                           valid_i,
    output logic                           ready_i,
    output INSTRUCTION_DECODED             instruction_o,
    output logic                           valid_o,
    input  logic                           ready_o,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    INSTRUCTION_DECODED mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic store;
    logic advance;

    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL);
        // Full is judged from the registered count only, so a pop in the
        // same cycle never opens a slot for a push.
        ready_i = !full && !reset;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        bypass        = empty && valid_i && !flush && !reset;
        valid_o       = !empty || bypass;
        instruction_o = empty ? instruction_i : mem[rd_ptr];
`else
        bypass        = 1'b0;
        valid_o       = !empty;
        instruction_o = mem[rd_ptr];
`endif
        push    = valid_i && ready_i;
        pop     = valid_o && ready_o;
        // A bypassed entry that is consumed immediately never touches storage.
        store   = push && !(bypass && ready_o);
        advance = pop && !(bypass && ready_o);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (advance) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, advance})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store && !flush) begin
            mem[wr_ptr] <= instruction_i;
        end
    end

endmodule
